// File: rtl/fifo_sync_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : fifo_sync_ctrl
// Brief    : Single-clock show-ahead FIFO controller driving an external
//            storage macro; owns pointers, handshakes and status flags.
// Revision : 1.0 - initial release
// ============================================================================
module fifo_sync_ctrl #(
    parameter int DEPTH    = 8,
    parameter int WIDTH    = 8,
    parameter int AF_LEVEL = DEPTH/2 - 1
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH-1:0]           in_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH-1:0]           out_data,
    output logic                       mem_en,
    output logic [$clog2(DEPTH)-2:0]   mem_w_addr,
    output logic [WIDTH-1:0]           mem_w_data,
    output logic [$clog2(DEPTH)-2:0]   mem_r_addr,
    input  logic [WIDTH-1:0]           mem_r_data,
    output logic [$clog2(DEPTH)-1:0]   count,
    output logic                       full,
    output logic                       empty,
    output logic                       almost_full
);

    localparam int             C_PW    = $clog2(DEPTH);
    localparam int             C_AW    = C_PW - 1;
    localparam logic [C_PW-1:0] C_ONE  = C_PW'(1);
    localparam logic [C_PW-1:0] C_AF   = C_PW'(AF_LEVEL);

    logic [C_PW-1:0] r_wptr;
    logic [C_PW-1:0] r_rptr;
    logic            w_push;
    logic            w_pop;
    logic            w_full;
    logic            w_empty;
    logic [C_PW-1:0] w_count;

    // Status is decoded only from registered pointers; the MSB is the wrap bit.
    assign w_empty = (r_wptr == r_rptr);
    assign w_full  = (r_wptr[C_AW-1:0] == r_rptr[C_AW-1:0]) &&
                     (r_wptr[C_AW] != r_rptr[C_AW]);
    assign w_count = r_wptr - r_rptr;

    assign w_push = in_valid & ~w_full;
    assign w_pop  = ~w_empty & out_ready;

    assign in_ready    = ~w_full;
    assign out_valid   = ~w_empty;
    assign out_data    = mem_r_data;
    assign full        = w_full;
    assign empty       = w_empty;
    assign count       = w_count;
    assign almost_full = (w_count >= C_AF);

    // Write strobe is suppressed during reset so discarded traffic never lands.
    assign mem_en     = w_push & ~reset;
    assign mem_w_addr = r_wptr[C_AW-1:0];
    assign mem_w_data = in_data;
    assign mem_r_addr = r_rptr[C_AW-1:0];

    always_ff @(posedge clock) begin
        if (reset) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + C_ONE;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + C_ONE;
            end
        end
    end

endmodule
`default_nettype wire
